// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI receive deserializer.
package spi_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int BC_W       = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } state_t;
endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead FIFO for received words; rdata always presents the oldest entry.
module spi_rx_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW:0]              wptr, rptr;
  logic                     do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot being overwritten.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/spi_rx_deser.sv
// SPI slave receive deserializer (CPOL=0, MSB first) with a ready/valid output store.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO store; otherwise a single holding register.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_l,
  input  logic              spi_sclk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic [BC_W-1:0]   bit_count
);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, data_sync;
  logic                   cs_s, sclk_s, data_s, sclk_d, rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      data_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_l};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign rise   = sclk_s && !sclk_d;

  // The final bit goes straight into the committed word, so only DATA_W-1 bits are stored.
  state_t            state, state_nxt;
  logic [DATA_W-2:0] sh, sh_nxt;
  logic [BC_W-1:0]   cnt_nxt;
  logic              commit, ferr_nxt, ovf_nxt;
  logic [DATA_W-1:0] commit_word;

  assign commit_word = {sh, data_s};

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = bit_count;
    commit    = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!cs_s) state_nxt = SHIFT;
      end
      SHIFT: begin
        // Final rise wins over a simultaneous cs_l rise: the word is complete.
        if (rise && bit_count == BC_W'(DATA_W - 1)) begin
          cnt_nxt   = bit_count + 1'b1;
          commit    = 1'b1;
          state_nxt = WAIT_END;
        end else if (cs_s) begin
          ferr_nxt  = (bit_count != '0);
          cnt_nxt   = '0;
          sh_nxt    = '0;
          state_nxt = IDLE;
        end else if (rise) begin
          sh_nxt  = {sh[DATA_W-3:0], data_s};
          cnt_nxt = bit_count + 1'b1;
        end
      end
      WAIT_END: begin
        if (cs_s) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      bit_count <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      bit_count <= cnt_nxt;
      frame_err <= ferr_nxt;
      overflow  <= ovf_nxt;
    end
  end

  logic st_full, pop, push;

  assign pop     = rx_valid && rx_ready;
  assign push    = commit && (!st_full || pop);
  assign ovf_nxt = commit && st_full && !pop;

`ifdef SPI_RX_FIFO_EN
  logic st_empty;

  spi_rx_fifo #(.DW(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (commit_word),
    .pop   (pop),
    .rdata (rx_data),
    .full  (st_full),
    .empty (st_empty)
  );
  assign rx_valid = !st_empty;
`else
  logic              hold_vld;
  logic [DATA_W-1:0] hold_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (push) begin
      hold_vld  <= 1'b1;
      hold_data <= commit_word;
    end else if (pop) begin
      hold_vld  <= 1'b0;
    end
  end

  assign st_full  = hold_vld;
  assign rx_valid = hold_vld;
  assign rx_data  = hold_data;
`endif
endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: frames, truncation, overflow, same-cycle pop, mid-frame reset.
module tb_spi_rx_deser;
  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;
`ifdef SPI_RX_FIFO_EN
  localparam int N = 4;
`else
  localparam int N = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              spi_cs_l, spi_sclk, spi_data, rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, frame_err, overflow;
  logic [4:0]        bit_count;

  spi_rx_deser #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_cs_l  (spi_cs_l),
    .spi_sclk  (spi_sclk),
    .spi_data  (spi_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int ferr_cnt = 0, ovf_cnt = 0, stab_err = 0;
  logic [DATA_W-1:0] rxq[$];
  logic [DATA_W-1:0] held;
  bit stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record transfers and pulses; also track rx_data stability while stalled.
  always @(negedge clk) begin
    if (reset) stall = 1'b0;
    else begin
      if (stall && rx_data !== held) stab_err++;
      stall = rx_valid && !rx_ready;
      held  = rx_data;
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
      if (frame_err === 1'b1) ferr_cnt++;
      if (overflow === 1'b1) ovf_cnt++;
    end
  end

  function automatic logic [DATA_W-1:0] ov_word(input int i);
`ifdef SPI_RX_FIFO_EN
    return DATA_W'(i + 1);
`else
    return DATA_W'((i + 1) * 32'h1111);
`endif
  endfunction

  // mode 0: normal; 1: pulse rx_ready on the final-bit commit cycle; 2: cs_l rises with final sclk
  task automatic send_frame(input logic [DATA_W-1:0] w, input int nbits, input bit end_cs,
                            input int mode);
    @(posedge clk); #1 spi_cs_l = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      #1 spi_sclk = 1'b0; spi_data = w[DATA_W-1-i];
      repeat (4) @(posedge clk);
      #1 spi_sclk = 1'b1;
      if (mode == 2 && i == nbits - 1) spi_cs_l = 1'b1;
      if (mode == 1 && i == nbits - 1) begin
        repeat (SYNC_STAGES) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        repeat (2) @(posedge clk);
      end else repeat (4) @(posedge clk);
    end
    #1 spi_sclk = 1'b0;
    repeat (4) @(posedge clk);
    if (end_cs) begin
      #1 spi_cs_l = 1'b1; spi_data = 1'b0;
      repeat (6) @(posedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; spi_cs_l = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_bitcnt", 32'(bit_count), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);

    // single frame
    send_frame(16'hA5C3, 16, 1'b1, 0);
    check("t1_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) check("t1_data", 32'(rxq[0]), 32'hA5C3);
    check("t1_ferr", 32'(ferr_cnt), 32'd0);
    check("t1_ovf", 32'(ovf_cnt), 32'd0);
    rxq.delete();

    // truncated after 7 bits, then a good frame
    send_frame(16'hFFFF, 7, 1'b1, 0);
    check("t2_ferr", 32'(ferr_cnt), 32'd1);
    check("t2_norx", 32'(rxq.size()), 32'd0);
    send_frame(16'h1234, 16, 1'b1, 0);
    check("t2_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) check("t2_data", 32'(rxq[0]), 32'h1234);
    check("t2_ferr_after", 32'(ferr_cnt), 32'd1);
    rxq.delete();

    // final sclk rise and cs_l rise seen together
    send_frame(16'h6789, 16, 1'b0, 2);
    repeat (6) @(posedge clk);
    check("t2b_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) check("t2b_data", 32'(rxq[0]), 32'h6789);
    check("t2b_ferr", 32'(ferr_cnt), 32'd1);
    rxq.delete();

    // overflow: fill store, one more frame dropped
    #1 rx_ready = 1'b0;
    for (int i = 0; i <= N; i++) send_frame(ov_word(i), 16, 1'b1, 0);
    check("t3_ovf", 32'(ovf_cnt), 32'd1);
    check("t3_valid", 32'(rx_valid), 32'd1);
    check("t3_head", 32'(rx_data), 32'(ov_word(0)));
    check("t3_norx", 32'(rxq.size()), 32'd0);
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (N + 3) @(posedge clk);
    check("t3_drain_n", 32'(rxq.size()), 32'(N));
    for (int i = 0; i < N && i < rxq.size(); i++) check("t3_drain", 32'(rxq[i]), 32'(ov_word(i)));
    check("t3_empty", 32'(rx_valid), 32'd0);
    #1 rx_ready = 1'b0;
    rxq.delete();

    // store full, pop in the same cycle as the next commit
    for (int i = 0; i < N; i++) send_frame(16'h0A00 + 16'(i), 16, 1'b1, 0);
    send_frame(16'h5A5A, 16, 1'b1, 1);
    check("t4_ovf", 32'(ovf_cnt), 32'd1);
    check("t4_one_pop", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) check("t4_pop_data", 32'(rxq[0]), 32'h0A00);
    check("t4_valid", 32'(rx_valid), 32'd1);
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (N + 3) @(posedge clk);
    check("t4_total", 32'(rxq.size()), 32'(N + 1));
    for (int i = 1; i < N && i < rxq.size(); i++)
      check("t4_order", 32'(rxq[i]), 32'h0A00 + 32'(i));
    if (rxq.size() > N) check("t4_last", 32'(rxq[N]), 32'h5A5A);
    rxq.delete();

    // reset in the middle of a frame
    send_frame(16'hFFFF, 9, 1'b0, 0);
    check("t5_bitcnt9", 32'(bit_count), 32'd9);
    #1 reset = 1'b1;
    #2;
    check("t5_rst_bitcnt", 32'(bit_count), 32'd0);
    check("t5_rst_valid", 32'(rx_valid), 32'd0);
    check("t5_rst_data", 32'(rx_data), 32'd0);
    check("t5_rst_ferr", 32'(frame_err), 32'd0);
    spi_cs_l = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    check("t5_no_ferr", 32'(ferr_cnt), 32'd1);
    check("t5_idle_cnt", 32'(bit_count), 32'd0);
    send_frame(16'hBEEF, 16, 1'b1, 0);
    check("t5_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) check("t5_data", 32'(rxq[0]), 32'hBEEF);
    check("t5_ferr_final", 32'(ferr_cnt), 32'd1);
    check("stable_data", 32'(stab_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_rx_deser.md
SPI_RX_DESER -- requirements
Module: spi_rx_deser

Interface
REQ-001 Parameter DATA_W, 16, frame length in bits; MSB first.
REQ-002 Parameter SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.
REQ-003 Parameter FIFO_DEPTH, 4, output FIFO entries when SPI_RX_FIFO_EN is defined; power of two.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 spi_cs_l  input  1  active-low chip select from the SPI master.
REQ-007 spi_sclk  input  1  SPI clock, CPOL=0; data is sampled on its rising edge.
REQ-008 spi_data  input  1  MOSI serial data.
REQ-009 rx_data  output  DATA_W  received word; valid when rx_valid=1.
REQ-010 rx_valid  output  1  word available.
REQ-011 rx_ready  input  1  consumer accepts; a word transfers when rx_valid and rx_ready are both 1 at a clk edge.
REQ-012 frame_err  output  1  one-cycle pulse when a frame is truncated.
REQ-013 overflow  output  1  one-cycle pulse when a completed word is dropped.
REQ-014 bit_count  output  5  bits captured in the current frame, 0..DATA_W.

Function
REQ-015 spi_cs_l, spi_sclk and spi_data SHALL each pass through a SYNC_STAGES flop synchronizer before use.
REQ-016 A sclk rise SHALL be detected when the synchronized sclk is 1 and its previous registered value is 0.
REQ-017 The inputs SHALL meet a minimum high and low time of 1 clk period on sclk and cs_l.
REQ-018 FSM states: IDLE, SHIFT, WAIT_END.
REQ-019 IDLE: bit_count=0; synchronized cs_l=0 -> SHIFT.
REQ-020 SHIFT, on each sclk rise: shift the synchronized data bit into the LSB of the shift register; bit_count+1.
REQ-021 SHIFT, on the sclk rise that makes bit_count=DATA_W: commit the word; -> WAIT_END.
REQ-022 SHIFT, synchronized cs_l=1 with 0<bit_count<DATA_W: pulse frame_err, discard partial word, -> IDLE.
REQ-023 SHIFT, synchronized cs_l=1 with bit_count=0: -> IDLE, no error.
REQ-024 If the final sclk rise and the cs_l rise are seen in the same cycle, the bit SHALL be captured and the word committed, with no frame_err.
REQ-025 WAIT_END: ignore further sclk rises; synchronized cs_l=1 -> IDLE.
REQ-026 Commit latency: rx_valid SHALL rise the clk cycle after the commit edge whenever the output store is not full.
REQ-027 Commit when the store is full and no pop occurs in that cycle: pulse overflow, drop the new word, retain stored words.
REQ-028 Commit when the store is full and a pop occurs in the same cycle: accept the new word, no overflow.
REQ-029 rx_data SHALL remain stable while rx_valid=1 and rx_ready=0.
REQ-030 Words SHALL be delivered in arrival order, with no duplication.

Reset
REQ-031 On reset assertion:
- FSM -> IDLE
- shift register, bit_count and rx_data = 0
- rx_valid, frame_err and overflow = 0
- store emptied
- synchronizers -> cs_l=1, sclk=0, data=0
REQ-032 A frame in progress at reset SHALL be abandoned with no frame_err.
REQ-033 After reset releases, the first frame whose cs_l falls after release SHALL be received normally.

Configuration
REQ-034 With SPI_RX_FIFO_EN defined, the output store SHALL be a FIFO_DEPTH-entry show-ahead FIFO.
REQ-035 With SPI_RX_FIFO_EN undefined, the output store SHALL be a single holding register.
REQ-036 In both builds, "full" means there is no free entry; handshake and latency are identical.

Structure
REQ-037 Package spi_pkg SHALL hold:
- DATA_W default
- FSM state enum (IDLE/SHIFT/WAIT_END)
- bit-count width constant
REQ-038 The FIFO SHALL be sub-module spi_rx_fifo (push/pop/full/empty, show-ahead), instantiated only under SPI_RX_FIFO_EN.

Verification
REQ-039 Single frame 0xA5C3, rx_ready=1 -> one rx_valid with rx_data=0xA5C3; frame_err=0 and overflow=0.
REQ-040 Truncated frame: cs_l rises after 7 bits -> one frame_err pulse, no rx_valid; next frame 0x1234 received correctly.
REQ-041 No FIFO, rx_ready=0, frames 0x1111 then 0x2222 -> overflow pulse on the second; rx_data holds 0x1111.
REQ-042 FIFO, rx_ready=0, five frames 0x0001..0x0005 -> overflow on the fifth; raising rx_ready then drains 0x0001..0x0004 in order.
REQ-043 Store full, rx_ready pulsed on the same cycle as the next commit -> new word accepted, no overflow.
REQ-044 Reset asserted at bit 9 of a frame -> all outputs reset, no frame_err; next frame 0xBEEF received correctly.
